// File: rtl/pe_operand_feeder.sv
// pe_operand_feeder
//   Transmit end of the PE operand interface. Buffers one vector of (a,b,c)
//   operand triples loaded from the controller/memory side, then streams them
//   into a PE (or the head of a PE chain) on its a/b/c/enable inputs. When the
//   stream stalls, enable drops and the operands hold their previous values,
//   which matches the PE's own hold behaviour.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset
//   wr_valid  load beat valid
//   wr_ready  feeder can accept a load beat (only in IDLE with buffer space)
//   wr_a/b/c  operand triple for the entry being written
//   start     begin streaming the loaded entries
//   stall     downstream hold request while streaming
//   enable    PE enable; a/b/c are valid this cycle
//   a/b/c     operands to the PE
//   busy      high while streaming and draining
//   done      one-cycle pulse when the drain completes
//   count     number of loaded entries
//
// All outputs are registered.

module pe_operand_feeder #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 8,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [WIDTH-1:0]           wr_a,
  input  logic [WIDTH-1:0]           wr_b,
  input  logic [WIDTH-1:0]           wr_c,
  input  logic                       start,
  input  logic                       stall,
  output logic                       enable,
  output logic [WIDTH-1:0]           a,
  output logic [WIDTH-1:0]           b,
  output logic [WIDTH-1:0]           c,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   rd_ptr;
  logic [CW-1:0]   len;
  logic [DW-1:0]   drain_cnt;

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [WIDTH-1:0] mem_c [DEPTH];

  logic             accept;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] first_a;
  logic [WIDTH-1:0] first_b;
  logic [WIDTH-1:0] first_c;

  // A load beat is only taken in IDLE; wr_ready is already low elsewhere,
  // the explicit state term keeps the write enable self-evidently safe.
  always_comb begin
    accept    = 1'b0;
    count_nxt = count;
    first_a   = mem_a[0];
    first_b   = mem_b[0];
    first_c   = mem_c[0];
    if (state == IDLE && wr_valid && wr_ready) begin
      accept    = 1'b1;
      count_nxt = count + CW'(1);
    end
    // start arriving together with the very first load beat: entry 0 is
    // being written this cycle, so forward the incoming triple directly.
    if (accept && count == '0) begin
      first_a = wr_a;
      first_b = wr_b;
      first_c = wr_c;
    end
  end

  // Operand buffer; contents survive a stream and are simply overwritten
  // from entry 0 by the next load.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_a[count[AW-1:0]] <= wr_a;
      mem_b[count[AW-1:0]] <= wr_b;
      mem_c[count[AW-1:0]] <= wr_c;
    end
  end

  // Control FSM with registered outputs. The start cycle itself issues the
  // first beat (unless stalled), so the first enable appears one cycle after
  // start. The transition to DRAIN happens on the edge that issues the last
  // beat, so enable is high for exactly L cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      len       <= '0;
      drain_cnt <= '0;
      count     <= '0;
      wr_ready  <= 1'b1;
      enable    <= 1'b0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          count  <= count_nxt;
          enable <= 1'b0;
          if (start && count_nxt != '0) begin
            len      <= count_nxt;
            busy     <= 1'b1;
            wr_ready <= 1'b0;
            if (!stall) begin
              enable    <= 1'b1;
              a         <= first_a;
              b         <= first_b;
              c         <= first_c;
              rd_ptr    <= CW'(1);
              drain_cnt <= '0;
              state     <= (count_nxt == CW'(1)) ? DRAIN : STREAM;
            end else begin
              rd_ptr <= '0;
              state  <= STREAM;
            end
          end else begin
            wr_ready <= (count_nxt < CW'(DEPTH));
          end
        end

        STREAM: begin
          if (!stall) begin
            enable <= 1'b1;
            a      <= mem_a[rd_ptr[AW-1:0]];
            b      <= mem_b[rd_ptr[AW-1:0]];
            c      <= mem_c[rd_ptr[AW-1:0]];
            rd_ptr <= rd_ptr + CW'(1);
            if (rd_ptr == len - CW'(1)) begin
              drain_cnt <= '0;
              state     <= DRAIN;
            end
          end else begin
            // Operands keep their last values while enable is low.
            enable <= 1'b0;
          end
        end

        DRAIN: begin
          enable <= 1'b0;
          a      <= '0;
          b      <= '0;
          c      <= '0;
          if (drain_cnt == DW'(DRAIN_CYCLES)) begin
            state    <= IDLE;
            done     <= 1'b1;
            busy     <= 1'b0;
            count    <= '0;
            wr_ready <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_operand_feeder.sv
// tb_pe_operand_feeder
//   Directed bench for pe_operand_feeder. Loaded triples are pushed to a
//   scoreboard queue and popped whenever a cycle is expected to carry a beat.

module tb_pe_operand_feeder;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_a = '0;
  logic [WIDTH-1:0] wr_b = '0;
  logic [WIDTH-1:0] wr_c = '0;
  logic             start = 1'b0;
  logic             stall = 1'b0;
  logic             enable;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             busy;
  logic             done;
  logic [CW-1:0]    count;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
  } beat_t;

  beat_t sb_q[$];
  beat_t last_beat = '0;
  int    total = 0;
  int    bad   = 0;

  pe_operand_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DRAIN_CYCLES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_a     (wr_a),
    .wr_b     (wr_b),
    .wr_c     (wr_c),
    .start    (start),
    .stall    (stall),
    .enable   (enable),
    .a        (a),
    .b        (b),
    .c        (c),
    .busy     (busy),
    .done     (done),
    .count    (count)
  );

  always #5 clk = ~clk;

  // Watchdog: the sequence is fixed-length, this only fires on a hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one load beat that is expected to be accepted and record it.
  task automatic apply_stimulus(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                input logic [WIDTH-1:0] vc);
    beat_t bt;
    wr_valid = 1'b1;
    wr_a = va;
    wr_b = vb;
    wr_c = vc;
    bt.a = va;
    bt.b = vb;
    bt.c = vc;
    sb_q.push_back(bt);
    tick();
  endtask

  // Sample one cycle at the falling edge and compare every output, then
  // advance to just after the next rising edge.
  task automatic expect_cycle(input string tag, input logic en, input logic bsy, input logic dn,
                              input logic zero_ops, input int cnt, input logic wrr);
    beat_t exp_b;
    exp_b = '0;
    @(negedge clk);
    check_output({tag, ".enable"}, 32'(enable), 32'(en));
    check_output({tag, ".busy"}, 32'(busy), 32'(bsy));
    check_output({tag, ".done"}, 32'(done), 32'(dn));
    check_output({tag, ".count"}, 32'(count), 32'(cnt));
    check_output({tag, ".wr_ready"}, 32'(wr_ready), 32'(wrr));
    if (en) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $error("[TB] FAIL %s.queue observed=empty expected=beat", tag);
      end else begin
        exp_b = sb_q.pop_front();
      end
      last_beat = exp_b;
    end else if (!zero_ops) begin
      exp_b = last_beat;
    end
    check_output({tag, ".a"}, 32'(a), 32'(exp_b.a));
    check_output({tag, ".b"}, 32'(b), 32'(exp_b.b));
    check_output({tag, ".c"}, 32'(c), 32'(exp_b.c));
    tick();
  endtask

  initial begin
    // Reset
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    expect_cycle("reset", 0, 0, 0, 1, 0, 1);

    // Full 8-beat load, rejected beats when full, start/wr_valid ignored in stream
    for (int i = 0; i < 8; i++)
      apply_stimulus(8'(i + 1), 8'(8 - i), 8'(2 * i + 1));
    wr_a = 8'h99;
    wr_b = 8'h99;
    wr_c = 8'h99;
    expect_cycle("t1.full0", 0, 0, 0, 1, 8, 0);
    expect_cycle("t1.full1", 0, 0, 0, 1, 8, 0);
    start = 1'b1;
    tick();
    for (int k = 0; k < 8; k++)
      expect_cycle("t1.beat", 1, 1, 0, 0, 8, 0);
    start = 1'b0;
    wr_valid = 1'b0;
    expect_cycle("t1.drain", 0, 1, 0, 1, 8, 0);
    expect_cycle("t1.drain", 0, 1, 0, 1, 8, 0);
    expect_cycle("t1.done", 0, 0, 1, 1, 0, 1);
    expect_cycle("t1.idle", 0, 0, 0, 1, 0, 1);
    check_output("t1.sb_empty", 32'(sb_q.size()), 32'd0);

    // Three entries with a two-cycle stall after the first beat
    apply_stimulus(8'h11, 8'h21, 8'h31);
    apply_stimulus(8'h12, 8'h22, 8'h32);
    apply_stimulus(8'h13, 8'h23, 8'h33);
    wr_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    stall = 1'b1;
    expect_cycle("t2.b0", 1, 1, 0, 0, 3, 0);
    expect_cycle("t2.stall0", 0, 1, 0, 0, 3, 0);
    stall = 1'b0;
    expect_cycle("t2.stall1", 0, 1, 0, 0, 3, 0);
    expect_cycle("t2.b1", 1, 1, 0, 0, 3, 0);
    expect_cycle("t2.b2", 1, 1, 0, 0, 3, 0);
    expect_cycle("t2.drain", 0, 1, 0, 1, 3, 0);
    expect_cycle("t2.drain", 0, 1, 0, 1, 3, 0);
    expect_cycle("t2.done", 0, 0, 1, 1, 0, 1);
    check_output("t2.sb_empty", 32'(sb_q.size()), 32'd0);

    // start with an empty buffer, then start together with the first load beat
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_cycle("t3.ignored", 0, 0, 0, 1, 0, 1);
    start = 1'b1;
    apply_stimulus(8'h05, 8'h06, 8'h07);
    start = 1'b0;
    wr_valid = 1'b0;
    expect_cycle("t3.beat", 1, 1, 0, 0, 1, 0);
    expect_cycle("t3.drain", 0, 1, 0, 1, 1, 0);
    expect_cycle("t3.drain", 0, 1, 0, 1, 1, 0);
    expect_cycle("t3.done", 0, 0, 1, 1, 0, 1);

    // Reset during the 4th beat of a 6-entry stream
    for (int i = 0; i < 6; i++)
      apply_stimulus(8'(8'h40 + i), 8'(8'h50 + i), 8'(8'h60 + i));
    wr_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++)
      expect_cycle("t4.beat", 1, 1, 0, 0, 6, 0);
    reset = 1'b0;
    #1;
    check_output("t4.rst.enable", 32'(enable), 32'd0);
    check_output("t4.rst.a", 32'(a), 32'd0);
    check_output("t4.rst.b", 32'(b), 32'd0);
    check_output("t4.rst.c", 32'(c), 32'd0);
    check_output("t4.rst.busy", 32'(busy), 32'd0);
    check_output("t4.rst.count", 32'(count), 32'd0);
    check_output("t4.rst.wr_ready", 32'(wr_ready), 32'd1);
    sb_q.delete();
    tick();
    expect_cycle("t4.inrst", 0, 0, 0, 1, 0, 1);
    reset = 1'b1;
    expect_cycle("t4.post", 0, 0, 0, 1, 0, 1);
    expect_cycle("t4.post", 0, 0, 0, 1, 0, 1);
    apply_stimulus(8'hA1, 8'hB1, 8'hC1);
    apply_stimulus(8'hA2, 8'hB2, 8'hC2);
    wr_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_cycle("t4.b0", 1, 1, 0, 0, 2, 0);
    expect_cycle("t4.b1", 1, 1, 0, 0, 2, 0);
    expect_cycle("t4.drain", 0, 1, 0, 1, 2, 0);
    expect_cycle("t4.drain", 0, 1, 0, 1, 2, 0);
    expect_cycle("t4.done", 0, 0, 1, 1, 0, 1);
    check_output("t4.sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_operand_feeder.md
Name: pe_operand_feeder

Overview:
- Transmit end of the PE operand interface: buffers one vector of (a,b,c) operand triples, then streams them into a PE (or the first PE of a chain) on the a/b/c/enable inputs.
- Sits between the attention controller/memory and the PE array.
- Preserves the PE's hold semantics: when the stream stalls, enable drops and the operands are held.

Parameters:
- WIDTH, 8, operand width; matches the PE a/b/c width.
- DEPTH, 8, buffer entries (maximum vector length K); power of two, ≥2.
- DRAIN_CYCLES, 2, idle cycles after the last beat so PE accumulators settle before done; ≥1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset.
- wr_valid  in  1  load beat valid.
- wr_ready  out  1  feeder can accept a load beat.
- wr_a  in  WIDTH  operand a for the entry being written.
- wr_b  in  WIDTH  operand b for the entry being written.
- wr_c  in  WIDTH  operand c for the entry being written.
- start  in  1  begin streaming the loaded entries.
- stall  in  1  downstream hold request during streaming.
- enable  out  1  PE enable; operands valid this cycle.
- a  out  WIDTH  operand a to the PE.
- b  out  WIDTH  operand b to the PE.
- c  out  WIDTH  operand c to the PE.
- busy  out  1  high in STREAM and DRAIN.
- done  out  1  one-cycle pulse when the drain completes.
- count  out  $clog2(DEPTH)+1  number of loaded entries.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; count, rd_ptr, drain counter = 0.
  - enable=0, a=b=c=0, busy=0, done=0, wr_ready=1.
  - Buffer contents are don't-care.
  - Reset asserted mid-stream aborts immediately; no done pulse.
- States: IDLE, STREAM, DRAIN. All outputs are registered.
- IDLE:
  - wr_ready = (count<DEPTH).
  - Load beat = wr_valid & wr_ready: writes the triple to entry count; count increments.
  - wr_valid while count==DEPTH: beat is not accepted, nothing changes.
  - start with count==0 is ignored.
  - start with count>0: go to STREAM, rd_ptr=0, stream length L=count.
  - start and an accepted load beat in the same cycle: the beat is written and included, so L=count+1.
- STREAM:
  - wr_ready=0.
  - Each cycle with stall=0: next cycle enable=1 and a/b/c = entry rd_ptr; rd_ptr increments.
  - First beat appears on the cycle after start (latency 1).
  - stall=1: next cycle enable=0, a/b/c hold their previous values, rd_ptr holds. A stall on the start cycle delays the first beat.
  - After beat L-1 is issued: go to DRAIN.
  - enable is high for exactly L cycles per stream, regardless of how many stalls occur.
  - start during STREAM is ignored.
- DRAIN:
  - enable=0, a=b=c=0, wr_ready=0.
  - Lasts DRAIN_CYCLES cycles; stall is ignored.
  - On exit: done=1 for one cycle, count=0, state=IDLE, busy=0 in that same cycle, wr_ready=1 in that same cycle.
- busy: 1 from the cycle after start is accepted through the last DRAIN cycle.
- Buffer contents are not cleared after a stream; a new load overwrites from entry 0.
- Operands are passed through unmodified; no arithmetic. Pointer wrap cannot occur because L≤DEPTH.

Test Plan:
- Reset then load 8 beats (a=1..8, b=8..1, c=1,3,..,15); start.
  - wr_ready drops after the 8th beat (count=8).
  - enable high cycles 1–8 after start, a=1..8, b=8..1, c=1..15 odd.
  - 2 drain cycles with a=b=c=0, then done pulse and busy=0.
- Load 3 entries; start with stall=1 on stream cycles 2 and 3.
  - enable pattern 1,0,0,1,1; a holds entry0 value during the stall.
  - Exactly 3 enable-high cycles.
- start with count=0, then wr_valid with start asserted in the same cycle (a=5).
  - First start ignored.
  - Second start produces a single beat a=5, followed by done.
- wr_valid while count=8, and wr_valid/start during STREAM.
  - No beat accepted, count unchanged, current stream unaffected.
- Assert reset=0 in the 4th stream beat.
  - Outputs zero immediately, count=0, no done pulse.
  - After release, a new 2-entry load/stream completes normally.
